// File: rtl/burst_mem_responder_pkg.sv
// Shared constants and types for the burst memory responder.
// Purpose: line/beat geometry, FSM state encoding and the line storage type
// used by burst_mem_responder and burst_mem_array.
package burst_mem_responder_pkg;

    localparam int unsigned LINE_BITS     = 256;
    localparam int unsigned BEAT_BITS     = 64;
    localparam int unsigned BURST_BEATS   = 4;
    localparam int unsigned OFFSET_BITS   = 5;
    localparam int unsigned BEAT_IDX_BITS = 2;
    localparam int unsigned LAT_BITS      = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        BURST = 2'd2,
        DONE  = 2'd3
    } burst_mem_state_t;

    typedef logic [LINE_BITS-1:0] mem_line_t;

endpackage

// File: rtl/burst_mem_array.sv
// Single-port line array backing the burst responder.
// Purpose: stores 2**IDX_WIDTH lines of 256 bits; writes one 64-bit beat per
// cycle, reads one 64-bit beat per cycle into a registered output.
// Ports:
//   clk, reset_n  clock / async active-low reset (output register only)
//   we_i          write the selected beat of line idx_i with wdata_i
//   re_i          load rdata_o with the selected beat of line idx_i
//   idx_i         line index
//   beat_i        beat select (beat 0 = bits [63:0])
//   wdata_i       write beat
//   rdata_o       registered read beat
module burst_mem_array
    import burst_mem_responder_pkg::*;
#(
    parameter int unsigned IDX_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     we_i,
    input  logic                     re_i,
    input  logic [IDX_WIDTH-1:0]     idx_i,
    input  logic [BEAT_IDX_BITS-1:0] beat_i,
    input  logic [BEAT_BITS-1:0]     wdata_i,
    output logic [BEAT_BITS-1:0]     rdata_o
);

    localparam int unsigned LINES = 2 ** IDX_WIDTH;

    mem_line_t               mem_q [LINES];
    logic [BEAT_BITS-1:0]    rdata_q;

    // Storage is deliberately not reset; an aborted burst keeps earlier beats.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[idx_i][{beat_i, 6'b0} +: BEAT_BITS] <= wdata_i;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[idx_i][{beat_i, 6'b0} +: BEAT_BITS];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/burst_mem_responder.sv
// Memory-side responder for the 64-bit burst physical-memory interface.
// Purpose: accepts one line read/write at a time, waits LATENCY cycles, then
// moves the 256-bit line as BEATS consecutive 64-bit beats strobed by
// pmem_resp, followed by one idle DONE cycle.
// Ports:
//   clk, reset_n             clock / async active-low reset
//   pmem_read, pmem_write    level requests, held until the last resp beat
//   pmem_address             byte address (line aligned, bits [4:0] ignored)
//   pmem_wdata               write beat, valid in each resp cycle of a write
//   pmem_resp                beat strobe
//   pmem_rdata               read beat, valid while pmem_resp during a read
//   protocol_err             sticky requester-violation flag
// Optional (macro BURST_MEM_STATS_EN): rd_count / wr_count completed-transfer
// counters.
module burst_mem_responder
    import burst_mem_responder_pkg::*;
#(
    parameter int unsigned IDX_WIDTH = 8,
    parameter int unsigned LATENCY   = 8,
    parameter int unsigned BEATS     = BURST_BEATS
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        pmem_read,
    input  logic        pmem_write,
    input  logic [31:0] pmem_address,
    input  logic [63:0] pmem_wdata,
    output logic        pmem_resp,
    output logic [63:0] pmem_rdata,
    output logic        protocol_err
`ifdef BURST_MEM_STATS_EN
    ,
    output logic [31:0] rd_count,
    output logic [31:0] wr_count
`endif
);

    localparam logic [BEAT_IDX_BITS-1:0] LAST_BEAT = BEAT_IDX_BITS'(BEATS - 1);
    localparam logic [LAT_BITS-1:0]      LAT_LOAD  = LAT_BITS'(LATENCY - 1);

    burst_mem_state_t           state_q, state_d;
    logic                       op_wr_q, op_wr_d;
    logic [IDX_WIDTH-1:0]       idx_q, idx_d;
    logic [LAT_BITS-1:0]        lat_q, lat_d;
    logic [BEAT_IDX_BITS-1:0]   beat_q, beat_d;
    logic                       resp_q, resp_d;
    logic                       err_q, err_d;
`ifdef BURST_MEM_STATS_EN
    logic [31:0]                rd_cnt_q, rd_cnt_d;
    logic [31:0]                wr_cnt_q, wr_cnt_d;
`endif

    logic                       arr_we;
    logic                       arr_re;
    logic [BEAT_IDX_BITS-1:0]   arr_beat;
    logic                       req_one;
    logic                       req_viol;
    logic                       unused_addr;

    assign unused_addr = ^{pmem_address[31:OFFSET_BITS+IDX_WIDTH],
                           pmem_address[OFFSET_BITS-1:0]};

    assign req_one = pmem_read ^ pmem_write;

    // Request no longer matches the latched op (dropped or switched).
    assign req_viol = op_wr_q ? !(pmem_write && !pmem_read)
                              : !(pmem_read && !pmem_write);

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_one) state_d = WAIT;
            WAIT:    if (lat_q == '0) state_d = BURST;
            BURST:   if (beat_q == LAST_BEAT) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath / output next values.
    always_comb begin
        op_wr_d  = op_wr_q;
        idx_d    = idx_q;
        lat_d    = lat_q;
        beat_d   = beat_q;
        resp_d   = 1'b0;
        err_d    = err_q;
        arr_we   = 1'b0;
        arr_re   = 1'b0;
`ifdef BURST_MEM_STATS_EN
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (pmem_read && pmem_write) begin
                    err_d = 1'b1;
                end else if (req_one) begin
                    op_wr_d = pmem_write;
                    idx_d   = pmem_address[OFFSET_BITS +: IDX_WIDTH];
                    lat_d   = LAT_LOAD;
                end
            end
            WAIT: begin
                if (req_viol) err_d = 1'b1;
                if (lat_q != '0) begin
                    lat_d = lat_q - 1'b1;
                end else begin
                    beat_d = '0;
                    resp_d = 1'b1;
                    arr_re = !op_wr_q;
                end
            end
            BURST: begin
                if (req_viol) err_d = 1'b1;
                arr_we = op_wr_q;
                if (beat_q != LAST_BEAT) begin
                    beat_d = beat_q + 1'b1;
                    resp_d = 1'b1;
                    arr_re = !op_wr_q;
                end
            end
            DONE: begin
`ifdef BURST_MEM_STATS_EN
                if (op_wr_q) wr_cnt_d = wr_cnt_q + 32'd1;
                else         rd_cnt_d = rd_cnt_q + 32'd1;
`endif
            end
            default: ;
        endcase
        // Writes use the beat on the bus now; reads prefetch the next beat.
        arr_beat = op_wr_q ? beat_q : beat_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_wr_q  <= 1'b0;
            idx_q    <= '0;
            lat_q    <= '0;
            beat_q   <= '0;
            resp_q   <= 1'b0;
            err_q    <= 1'b0;
`ifdef BURST_MEM_STATS_EN
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
`endif
        end else begin
            op_wr_q  <= op_wr_d;
            idx_q    <= idx_d;
            lat_q    <= lat_d;
            beat_q   <= beat_d;
            resp_q   <= resp_d;
            err_q    <= err_d;
`ifdef BURST_MEM_STATS_EN
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
`endif
        end
    end

    burst_mem_array #(
        .IDX_WIDTH (IDX_WIDTH)
    ) u_array (
        .clk     (clk),
        .reset_n (reset_n),
        .we_i    (arr_we),
        .re_i    (arr_re),
        .idx_i   (idx_q),
        .beat_i  (arr_beat),
        .wdata_i (pmem_wdata),
        .rdata_o (pmem_rdata)
    );

    assign pmem_resp    = resp_q;
    assign protocol_err = err_q;
`ifdef BURST_MEM_STATS_EN
    assign rd_count     = rd_cnt_q;
    assign wr_count     = wr_cnt_q;
`endif

endmodule

// File: tb/tb_burst_mem_responder.sv
// Bench for burst_mem_responder: dut0 uses LATENCY=8, dut1 uses LATENCY=1.
// Drivers push expected beats (cycle + data) into a scoreboard; a monitor
// pops and compares every beat either DUT strobes.
module tb_burst_mem_responder;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        rd    [2];
    logic        wr    [2];
    logic [31:0] addr  [2];
    logic [63:0] wd    [2];
    logic        resp  [2];
    logic [63:0] rdata [2];
    logic        err   [2];
`ifdef BURST_MEM_STATS_EN
    logic [31:0] rdc   [2];
    logic [31:0] wrc   [2];
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int          dut;
        int          cyc;
        bit          chk;
        logic [63:0] data;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    burst_mem_responder #(.IDX_WIDTH(8), .LATENCY(8)) dut0 (
        .clk(clk), .reset_n(reset_n),
        .pmem_read(rd[0]), .pmem_write(wr[0]),
        .pmem_address(addr[0]), .pmem_wdata(wd[0]),
        .pmem_resp(resp[0]), .pmem_rdata(rdata[0]), .protocol_err(err[0])
`ifdef BURST_MEM_STATS_EN
        , .rd_count(rdc[0]), .wr_count(wrc[0])
`endif
    );

    burst_mem_responder #(.IDX_WIDTH(8), .LATENCY(1)) dut1 (
        .clk(clk), .reset_n(reset_n),
        .pmem_read(rd[1]), .pmem_write(wr[1]),
        .pmem_address(addr[1]), .pmem_wdata(wd[1]),
        .pmem_resp(resp[1]), .pmem_rdata(rdata[1]), .protocol_err(err[1])
`ifdef BURST_MEM_STATS_EN
        , .rd_count(rdc[1]), .wr_count(wrc[1])
`endif
    );

    // Monitor: every strobed beat must match the oldest pending entry of its DUT.
    always @(posedge clk) begin
        int   idx;
        exp_t e;
        #1;
        for (int d = 0; d < 2; d++) begin
            if (resp[d] === 1'b1) begin
                idx = -1;
                foreach (sb[i]) if (idx < 0 && sb[i].dut == d) idx = i;
                checks++;
                if (idx < 0) begin
                    failures++;
                    $display("FAIL resp_unexpected dut%0d cyc=%0d got resp=1 want resp=0", d, cyc);
                end else begin
                    e = sb[idx];
                    sb.delete(idx);
                    if (e.cyc != cyc || (e.chk && rdata[d] !== e.data)) begin
                        failures++;
                        $display("FAIL beat dut%0d got cyc=%0d data=%h want cyc=%0d data=%h",
                                 d, cyc, rdata[d], e.cyc, e.data);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic push_beats(input int d, input int first_cyc, input int n,
                              input bit chk, input logic [255:0] line);
        exp_t e;
        for (int b = 0; b < n; b++) begin
            e.dut  = d;
            e.cyc  = first_cyc + b;
            e.chk  = chk;
            e.data = line[64*b +: 64];
            sb.push_back(e);
        end
    endtask

    // Called at a negedge. delay = edges until acceptance (2 when chained from DONE).
    // line is write data for writes and the expected line for reads.
    task automatic txn(input int d, input bit is_wr, input logic [31:0] a,
                       input logic [255:0] line, input int lat, input int delay,
                       input bit hold);
        int cnt;
        int guard;
        rd[d]   = !is_wr;
        wr[d]   = is_wr;
        addr[d] = a;
        wd[d]   = line[63:0];
        push_beats(d, cyc + delay + lat, 4, !is_wr, line);
        cnt   = 0;
        guard = 0;
        while (cnt < 4 && guard < 60) begin
            @(negedge clk);
            guard++;
            if (resp[d] === 1'b1) begin
                wd[d] = line[64*cnt +: 64];
                cnt++;
            end
        end
        if (cnt < 4) begin
            checks++;
            failures++;
            $display("FAIL txn_timeout dut%0d got beats=%0d want beats=4", d, cnt);
        end
        @(negedge clk);
        if (!hold) begin
            rd[d] = 1'b0;
            wr[d] = 1'b0;
            @(negedge clk);
        end
    endtask

    localparam logic [255:0] LINE_A = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                       64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    localparam logic [255:0] LINE_B = {64'h8888_8888_8888_8888, 64'h7777_7777_7777_7777,
                                       64'h6666_6666_6666_6666, 64'h5555_5555_5555_5555};
    localparam logic [255:0] LINE_C = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                                       64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
    localparam logic [255:0] LINE_AB = {64'h8888_8888_8888_8888, 64'h7777_7777_7777_7777,
                                        64'h6666_6666_6666_6666, 64'hAAAA_AAAA_AAAA_AAAA};
    localparam logic [255:0] LINE_D = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                                       64'hDEAD_BEEF_0000_0001, 64'hCAFE_F00D_0000_0002};

    initial begin
        int cnt;
        int guard;
        reset_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            rd[d] = 1'b0; wr[d] = 1'b0; addr[d] = '0; wd[d] = '0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("rst_resp%0d", d), 64'(resp[d]), 64'd0);
            check($sformatf("rst_rdata%0d", d), rdata[d], 64'd0);
            check($sformatf("rst_err%0d", d), 64'(err[d]), 64'd0);
        end
        reset_n = 1'b1;
        @(negedge clk);

        // Write then read back, LATENCY=8.
        txn(0, 1'b1, 32'h0000_0040, LINE_A, 8, 1, 1'b0);
        txn(0, 1'b0, 32'h0000_0040, LINE_A, 8, 1, 1'b0);

        // Upper address bits wrap onto the same line.
        txn(0, 1'b1, 32'h0000_2040, LINE_B, 8, 1, 1'b0);
        txn(0, 1'b0, 32'h0000_0040, LINE_B, 8, 1, 1'b0);
        check("alias_err", 64'(err[0]), 64'd0);

        // Offset bits ignored.
        txn(0, 1'b0, 32'h0000_005C, LINE_B, 8, 1, 1'b0);

        // Reset during beat 1 of a write: only beat 0 lands.
        rd[0] = 1'b0; wr[0] = 1'b1; addr[0] = 32'h0000_0040; wd[0] = LINE_C[63:0];
        push_beats(0, cyc + 1 + 8, 2, 1'b0, LINE_C);
        cnt = 0;
        guard = 0;
        while (cnt < 2 && guard < 40) begin
            @(negedge clk);
            guard++;
            if (resp[0] === 1'b1) begin
                wd[0] = LINE_C[64*cnt +: 64];
                cnt++;
            end
        end
        if (cnt < 2) begin
            checks++;
            failures++;
            $display("FAIL abort_timeout got beats=%0d want beats=2", cnt);
        end
        reset_n = 1'b0;
        #1;
        check("abort_resp_drop", 64'(resp[0]), 64'd0);
        wr[0] = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        txn(0, 1'b0, 32'h0000_0040, LINE_AB, 8, 1, 1'b0);

        // LATENCY=1: write, then two reads back to back (request held through DONE).
        txn(1, 1'b1, 32'h0000_0060, LINE_D, 1, 1, 1'b0);
        txn(1, 1'b0, 32'h0000_0060, LINE_D, 1, 1, 1'b1);
        txn(1, 1'b0, 32'h0000_0060, LINE_D, 1, 2, 1'b0);
`ifdef BURST_MEM_STATS_EN
        check("rd_count1", 64'(rdc[1]), 64'd2);
        check("wr_count1", 64'(wrc[1]), 64'd1);
`endif
        check("b2b_err1", 64'(err[1]), 64'd0);

        // Read and write together in IDLE: no transfer, sticky error.
        rd[0] = 1'b1; wr[0] = 1'b1; addr[0] = 32'h0000_0040;
        repeat (20) @(negedge clk);
        check("both_err_set", 64'(err[0]), 64'd1);
        rd[0] = 1'b0; wr[0] = 1'b0;
        repeat (5) @(negedge clk);
        check("both_err_sticky", 64'(err[0]), 64'd1);
        check("both_err_other", 64'(err[1]), 64'd0);
        reset_n = 1'b0;
        @(negedge clk);
        check("err_cleared", 64'(err[0]), 64'd0);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
